// File: rtl/uart_rx_port.sv
// 8N1 UART receiver for the RAT MCU port bus: a 4-deep receive FIFO read through
// input ports, popped and flag-cleared through OUT writes to an ack port.
module uart_rx_port #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] DATA_ID      = 8'h30,
    parameter logic [7:0] STATUS_ID    = 8'h31,
    parameter logic [7:0] ACK_ID       = 8'h32,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       RX,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] DATA_OUT,
    output logic       SEL,
    output logic       INTR
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [BAUD_W-1:0] HALF_BIT = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_BIT = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic              rx_meta_q, rx_s_q;
    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overrun_q, overrun_d, framing_q, framing_d;
    logic              intr_q, intr_d;
    logic [7:0]        fifo_mem_q [FIFO_DEPTH];

    logic       stop_valid, stop_ok;
    logic       ack, pop, push, fifo_empty, fifo_full;
    logic [7:0] head, status;
    logic       unused_out_bits;

    assign unused_out_bits = ^OUT_PORT[7:3];

    // Serial receive FSM; stop_valid marks the single cycle the stop bit is sampled.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        stop_valid = 1'b0;
        stop_ok    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    baud_d  = '0;
                end
            end
            S_START: begin
                if (baud_q == HALF_BIT) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == FULL_BIT) begin
                    baud_d             = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                if (baud_q == FULL_BIT) begin
                    stop_valid = 1'b1;
                    stop_ok    = rx_s_q;
                    baud_d     = '0;
                    state_d    = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
        endcase
    end

    // A pop in the stop-sample cycle frees a slot, so a full FIFO still accepts the byte.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_FULL);
        ack        = IO_STRB && (PORT_ID == ACK_ID);
        pop        = ack && OUT_PORT[0] && !fifo_empty;
        push       = stop_valid && stop_ok && (!fifo_full || pop);
        overrun_d  = (stop_valid && stop_ok && fifo_full && !pop) ||
                     (overrun_q && !(ack && OUT_PORT[1]));
        framing_d  = (stop_valid && !stop_ok) || (framing_q && !(ack && OUT_PORT[2]));
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        intr_d     = push;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
            intr_q    <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            framing_q <= framing_d;
            intr_q    <= intr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem_q[wr_ptr_q] <= shift_q;
    end

    assign head   = fifo_mem_q[rd_ptr_q];
    assign status = {state_q != S_IDLE, 3'(count_q), framing_q, overrun_q, fifo_full, !fifo_empty};
    assign INTR   = intr_q;
    assign SEL    = (PORT_ID == DATA_ID) || (PORT_ID == STATUS_ID);

    always_comb begin
        DATA_OUT = 8'h00;
        if (PORT_ID == DATA_ID) begin
            DATA_OUT = fifo_empty ? 8'h00 : head;
        end else if (PORT_ID == STATUS_ID) begin
            DATA_OUT = status;
        end
    end

endmodule
